spi_frame_sequencer: RTL and testbench
======================================

Name: spi_frame_sequencer

Overview:
- Host-side front end sitting directly upstream of the SPI master byte engine (8-bit, mode 1).
- Buffers outgoing bytes in a TX FIFO and hands them to the engine one at a time.
- Owns slave-select timing across a multi-byte frame.
- Collects each byte returned by the engine into an RX FIFO for the host.

Parameters:
- FIFO_DEPTH, 4: entries in each of the TX and RX FIFOs; power of two, 2..16.
- SETUP_CYC, 2: clk cycles between ss falling and first eng_start; also between last eng_done and ss rising.
- LEN_W, 5: width of frame_len; max frame = 2^LEN_W-1 bytes.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX FIFO not full.
- frame_len  in  LEN_W  bytes in the next frame.
- frame_start  in  1  one-cycle request to begin a frame.
- frame_busy  out  1  frame in progress.
- rx_data  out  8  head of RX FIFO.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  host pops RX head.
- rx_overflow  out  1  one-cycle pulse when a received byte is dropped.
- ss  out  1  slave select, active low.
- eng_data_in  out  8  byte presented to the engine, held stable from eng_start until eng_done.
- eng_start  out  1  one-cycle pulse to start an engine byte.
- eng_done  in  1  one-cycle pulse: byte finished, eng_data_out valid.
- eng_data_out  in  8  byte received by the engine.

Behaviour:
- Reset (synchronous, active high): on any clk edge with rst=1, state=IDLE and both FIFOs are flushed.
- Reset output values: ss=1, eng_start=0, eng_data_in=0, frame_busy=0, rx_valid=0, rx_overflow=0, tx_ready=1. Reset mid-frame aborts immediately; the engine is not notified.
- TX FIFO: push when tx_valid&&tx_ready; tx_ready=!full. A push on empty in the same cycle as a pop attempt: only the push takes effect.
- RX FIFO: pop when rx_valid&&rx_ready. If full when eng_done arrives and no pop occurs that cycle, the byte is dropped and rx_overflow pulses. Full with a simultaneous pop: push accepted, no overflow.
- FSM states: IDLE, SETUP, LOAD, WAIT, HOLD.
- IDLE: frame_start with frame_len!=0 latches remaining=frame_len. Next cycle: SETUP, ss=0, frame_busy=1. frame_start with frame_len=0 is ignored. frame_start in any state other than IDLE is ignored.
- SETUP: count SETUP_CYC cycles, then go to LOAD.
- LOAD: if TX not empty, pop, drive eng_data_in, pulse eng_start, then go to WAIT. If TX is empty, stall in LOAD with ss held low, indefinitely.
- WAIT: on eng_done, push eng_data_out to RX and decrement remaining. If remaining becomes 0, go to HOLD; else go to LOAD.
- eng_done outside WAIT is ignored.
- HOLD: count SETUP_CYC cycles, then ss=1, frame_busy=0, go to IDLE.
- Latency: frame_start to ss low = 1 cycle; ss low to first eng_start = SETUP_CYC+1 cycles (LOAD with data ready); eng_done to next eng_start = 2 cycles.
- FIFO pointers: LOG2(FIFO_DEPTH)+1 bits; wrap modulo depth; full/empty from the MSB comparison.

Optional Feature:
- Macro: SPI_FRAME_LOOPBACK_EN.
- When defined: adds input port loopback (1 bit). When loopback=1, the eng_data_out path is replaced internally by the popped TX byte, captured on eng_done; eng_start/ss still toggle normally.
- When undefined: the port and mux are absent; RX always takes eng_data_out.

Decomposition:
- Package spi_pkg: byte_t (logic[7:0]), state enum seq_state_e, default constants SPI_FIFO_DEPTH=4, SPI_SETUP_CYC=2.
- Sub-module spi_byte_fifo (parameter DEPTH; push/pop/full/empty/data), instantiated twice, for TX and RX.

Test Plan:
- Reset mid-frame: push 3 bytes, frame_len=3, assert rst during second WAIT -> next cycle ss=1, frame_busy=0, tx_ready=1, rx_valid=0.
- Single byte: push 0xA5, frame_len=1; engine model returns 0x3C -> ss low 1 cycle after start; eng_start 3 cycles later with eng_data_in=0xA5; RX pops 0x3C; ss high SETUP_CYC cycles after eng_done.
- Four-byte burst: push 0x01..0x04, frame_len=4 -> four eng_start pulses in order 0x01..0x04; ss stays low throughout; RX returns echo bytes in order.
- TX underrun: frame_len=2, push only 0x11 -> after first byte, FSM stalls in LOAD with ss=0. Push 0x22 five cycles later -> eng_start next cycle; frame completes.
- RX overflow: DEPTH=4, rx_ready=0, frame_len=5 -> fifth eng_done gives rx_overflow pulse; RX holds first four bytes.
- Ignored requests: frame_len=0 start -> ss stays 1. frame_start while busy -> no effect on remaining count. Stray eng_done in IDLE -> RX unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and default constants for the SPI frame sequencer.
package spi_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOAD  = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } seq_state_e;

  localparam int SPI_FIFO_DEPTH = 4;
  localparam int SPI_SETUP_CYC  = 2;
  localparam int SPI_LEN_W      = 5;

endpackage

// File: rtl/spi_byte_fifo.sv
// Byte FIFO with one extra pointer bit to tell full from empty. A push into a
// full FIFO is accepted only when a pop frees the head slot in the same cycle.
module spi_byte_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = SPI_FIFO_DEPTH
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  byte_t push_data,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output byte_t data
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);

  byte_t         mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Occupancy flags, head data and the operations actually accepted this cycle
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    data      = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Pointer and storage update; reset flushes the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        wr_ptr_r                <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/spi_frame_sequencer.sv
// Host-side SPI frame sequencer: TX/RX byte FIFOs around an 8-bit engine with
// slave-select framing. Define SPI_FRAME_LOOPBACK_EN to add the loopback input.
module spi_frame_sequencer
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = SPI_FIFO_DEPTH,
  parameter int SETUP_CYC  = SPI_SETUP_CYC,
  parameter int LEN_W      = SPI_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             frame_start,
  output logic             frame_busy,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overflow,
  output logic             ss,
  output logic [7:0]       eng_data_in,
  output logic             eng_start,
  input  logic             eng_done,
`ifdef SPI_FRAME_LOOPBACK_EN
  input  logic             loopback,
`endif
  input  logic [7:0]       eng_data_out
);

  localparam int CNT_W = $clog2(SETUP_CYC + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);

  seq_state_e       state_r;
  seq_state_e       state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [LEN_W-1:0] rem_r;
  logic [LEN_W-1:0] rem_s;
  logic             ss_r;
  logic             ss_s;
  logic             busy_r;
  logic             busy_s;
  logic             eng_start_r;
  logic             eng_start_s;
  byte_t            eng_data_r;
  byte_t            eng_data_s;
  logic             ovf_r;
  logic             ovf_s;

  logic             tx_pop_s;
  logic             tx_full_s;
  logic             tx_empty_s;
  byte_t            tx_head_s;
  logic             rx_push_s;
  byte_t            rx_push_data_s;
  logic             rx_pop_s;
  logic             rx_full_s;
  logic             rx_empty_s;

  assign tx_ready    = !tx_full_s;
  assign rx_valid    = !rx_empty_s;
  assign rx_pop_s    = rx_valid && rx_ready;
  assign ss          = ss_r;
  assign frame_busy  = busy_r;
  assign eng_start   = eng_start_r;
  assign eng_data_in = eng_data_r;
  assign rx_overflow = ovf_r;

`ifdef SPI_FRAME_LOOPBACK_EN
  // In loopback the byte handed to the engine comes straight back into RX
  assign rx_push_data_s = loopback ? eng_data_r : eng_data_out;
`else
  assign rx_push_data_s = eng_data_out;
`endif

  spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_valid && tx_ready),
    .push_data (tx_data),
    .pop       (tx_pop_s),
    .full      (tx_full_s),
    .empty     (tx_empty_s),
    .data      (tx_head_s)
  );

  spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push_s),
    .push_data (rx_push_data_s),
    .pop       (rx_pop_s),
    .full      (rx_full_s),
    .empty     (rx_empty_s),
    .data      (rx_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state plus next values of the registered frame outputs
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    rem_s       = rem_r;
    ss_s        = ss_r;
    busy_s      = busy_r;
    eng_start_s = 1'b0;
    eng_data_s  = eng_data_r;
    tx_pop_s    = 1'b0;
    rx_push_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (frame_start && (frame_len != LEN_ZERO)) begin
          state_s = SETUP;
          rem_s   = frame_len;
          cnt_s   = CNT_ZERO;
          ss_s    = 1'b0;
          busy_s  = 1'b1;
        end else begin
          ss_s    = 1'b1;
          busy_s  = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_r == CNT_LAST) begin
          state_s = LOAD;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      LOAD: begin
        // An empty TX FIFO stalls here with ss kept low
        if (!tx_empty_s) begin
          tx_pop_s    = 1'b1;
          eng_data_s  = tx_head_s;
          eng_start_s = 1'b1;
          state_s     = WAIT;
        end else begin
          state_s     = LOAD;
        end
      end
      WAIT: begin
        if (eng_done) begin
          rx_push_s = 1'b1;
          rem_s     = rem_r - LEN_ONE;
          if (rem_r == LEN_ONE) begin
            state_s = HOLD;
            cnt_s   = CNT_ZERO;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s   = WAIT;
        end
      end
      HOLD: begin
        if (cnt_r == CNT_LAST) begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
          ss_s    = 1'b1;
          busy_s  = 1'b0;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
        ss_s    = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // A received byte is dropped only when RX is full and the host is not popping
  always_comb begin
    if (rx_push_s && rx_full_s && !rx_pop_s) begin
      ovf_s = 1'b1;
    end else begin
      ovf_s = 1'b0;
    end
  end

  // Registered frame outputs, counters and byte count
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= CNT_ZERO;
      rem_r       <= LEN_ZERO;
      ss_r        <= 1'b1;
      busy_r      <= 1'b0;
      eng_start_r <= 1'b0;
      eng_data_r  <= 8'h00;
      ovf_r       <= 1'b0;
    end else begin
      cnt_r       <= cnt_s;
      rem_r       <= rem_s;
      ss_r        <= ss_s;
      busy_r      <= busy_s;
      eng_start_r <= eng_start_s;
      eng_data_r  <= eng_data_s;
      ovf_r       <= ovf_s;
    end
  end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed-plus-random bench for spi_frame_sequencer with a queue-based
// engine/host reference model.
module tb_spi_frame_sequencer;

  localparam int DEPTH = 4;
  localparam int SETUP = 2;
  localparam int LW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [LW-1:0] frame_len;
  logic          frame_start;
  logic          frame_busy;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          rx_overflow;
  logic          ss;
  logic [7:0]    eng_data_in;
  logic          eng_start;
  logic          eng_done;
  logic [7:0]    eng_data_out;
`ifdef SPI_FRAME_LOOPBACK_EN
  logic          loopback = 1'b0;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] sent_q[$];
  logic [7:0] ret_q[$];
  logic [7:0] popped_q[$];
  logic [7:0] pushed_q[$];
  int  eng_mode;
  int  eng_delay;
  bit  eng_rand;
  int  pop_at_byte;
  int  ovf_cnt;
  int  ss_glitch;
  bit  mon_en;

  always #5 clk = ~clk;

  spi_frame_sequencer #(.FIFO_DEPTH(DEPTH), .SETUP_CYC(SETUP), .LEN_W(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .frame_len    (frame_len),
    .frame_start  (frame_start),
    .frame_busy   (frame_busy),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_overflow  (rx_overflow),
    .ss           (ss),
    .eng_data_in  (eng_data_in),
    .eng_start    (eng_start),
    .eng_done     (eng_done),
`ifdef SPI_FRAME_LOOPBACK_EN
    .loopback     (loopback),
`endif
    .eng_data_out (eng_data_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Engine model: answers each eng_start with an eng_done after a delay
  initial begin : engine
    logic [7:0] v;
    int d;
    forever begin
      @(negedge clk);
      if (eng_start === 1'b1) begin
        sent_q.push_back(eng_data_in);
        if (eng_mode == 0)      v = eng_data_in;
        else if (eng_mode == 1) v = 8'h3C;
        else                    v = 8'($urandom);
        d = eng_rand ? int'($urandom_range(0, 3)) : eng_delay;
        repeat (d) @(negedge clk);
        eng_data_out = v;
        eng_done     = 1'b1;
        ret_q.push_back(v);
        if (pop_at_byte != 0 && ret_q.size() == pop_at_byte && rx_valid === 1'b1) begin
          popped_q.push_back(rx_data);
          rx_ready = 1'b1;
        end
        @(negedge clk);
        eng_done     = 1'b0;
        eng_data_out = 8'h00;
        if (pop_at_byte != 0) rx_ready = 1'b0;
      end
    end
  end

  // Overflow pulse counter and ss/frame_busy consistency monitor
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rx_overflow === 1'b1) ovf_cnt++;
      if (mon_en && (ss !== ~frame_busy)) ss_glitch++;
    end
  end

  task automatic clear_model();
    sent_q.delete();
    ret_q.delete();
    popped_q.delete();
    pushed_q.delete();
    ovf_cnt = 0;
  endtask

  task automatic push_tx(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_wait", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    pushed_q.push_back(b);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic start_frame(input int len);
    @(negedge clk);
    frame_len   = LW'(len);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_busy === 1'b1 && n < max_cyc);
    check("frame_idle_timeout", frame_busy, 0);
  endtask

  task automatic drain(input logic [7:0] exp);
    check("rx_valid", rx_valid, 1);
    check("rx_data", rx_data, exp);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin : main
    int len;
    rst = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; frame_len = '0; frame_start = 1'b0;
    rx_ready = 1'b0; eng_done = 1'b0; eng_data_out = 8'h00;
    eng_mode = 0; eng_delay = 0; eng_rand = 1'b0; pop_at_byte = 0; mon_en = 1'b0;
    ovf_cnt = 0; ss_glitch = 0;

    // Reset values
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ss", ss, 1);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_data_in", eng_data_in, 8'h00);
    check("rst_frame_busy", frame_busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_overflow", rx_overflow, 0);
    check("rst_tx_ready", tx_ready, 1);
    mon_en = 1'b1;

    // Single byte with exact latencies: done arrives 2 cycles after eng_start
    clear_model(); eng_mode = 1; eng_rand = 1'b0; eng_delay = 2;
    push_tx(8'hA5);
    start_frame(1);
    check("single_ss_low", ss, 0);
    check("single_busy", frame_busy, 1);
    repeat (2) @(negedge clk);
    check("single_no_early_start", eng_start, 0);
    @(negedge clk);
    check("single_eng_start", eng_start, 1);
    check("single_eng_data_in", eng_data_in, 8'hA5);
    repeat (4) @(negedge clk);
    check("single_ss_hold", ss, 0);
    @(negedge clk);
    check("single_ss_high", ss, 1);
    check("single_busy_low", frame_busy, 0);
    drain(8'h3C);
    check("single_rx_empty", rx_valid, 0);

    // Four-byte burst 01..04 with echo responses
    clear_model(); eng_mode = 0; eng_rand = 1'b1;
    for (int i = 1; i <= 4; i++) push_tx(8'(i));
    start_frame(4);
    wait_idle(200);
    check("burst_sent_cnt", sent_q.size(), 4);
    for (int i = 0; i < 4; i++) check("burst_tx_order", sent_q[i], 8'(i + 1));
    for (int i = 0; i < 4; i++) drain(8'(i + 1));
    check("burst_no_ovf", ovf_cnt, 0);

    // Random frames with random engine responses
    for (int it = 0; it < 3; it++) begin
      clear_model(); eng_mode = 2; eng_rand = 1'b1;
      len = int'($urandom_range(1, 4));
      for (int i = 0; i < len; i++) push_tx(8'($urandom));
      start_frame(len);
      wait_idle(200);
      check("rand_sent_cnt", sent_q.size(), len);
      for (int i = 0; i < len; i++) check("rand_tx_order", sent_q[i], pushed_q[i]);
      for (int i = 0; i < len; i++) drain(ret_q[i]);
      check("rand_rx_empty", rx_valid, 0);
    end

    // TX underrun: stall in LOAD until the second byte shows up
    clear_model(); eng_mode = 0; eng_rand = 1'b0; eng_delay = 1;
    push_tx(8'h11);
    start_frame(2);
    repeat (20) @(negedge clk);
    check("underrun_ss_low", ss, 0);
    check("underrun_busy", frame_busy, 1);
    check("underrun_sent_cnt", sent_q.size(), 1);
    tx_data = 8'h22; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("underrun_no_start_yet", eng_start, 0);
    @(negedge clk);
    check("underrun_eng_start", eng_start, 1);
    check("underrun_eng_data_in", eng_data_in, 8'h22);
    wait_idle(100);
    drain(8'h11);
    drain(8'h22);

    // RX overflow: host idle, 5-byte frame into a 4-deep RX FIFO
    clear_model(); eng_mode = 2; eng_rand = 1'b1;
    for (int i = 0; i < 4; i++) push_tx(8'($urandom));
    start_frame(5);
    push_tx(8'($urandom));
    wait_idle(300);
    check("ovf_sent_cnt", sent_q.size(), 5);
    check("ovf_pulses", ovf_cnt, 1);
    for (int i = 0; i < 4; i++) drain(ret_q[i]);
    check("ovf_rx_empty", rx_valid, 0);

    // RX full with a pop in the same cycle as the 5th done: nothing dropped
    clear_model(); eng_mode = 2; eng_rand = 1'b1; pop_at_byte = 5;
    for (int i = 0; i < 4; i++) push_tx(8'($urandom));
    start_frame(5);
    push_tx(8'($urandom));
    wait_idle(300);
    pop_at_byte = 0;
    check("simpop_no_ovf", ovf_cnt, 0);
    check("simpop_popped_cnt", popped_q.size(), 1);
    check("simpop_popped_head", popped_q[0], ret_q[0]);
    for (int i = 1; i < 5; i++) drain(ret_q[i]);
    check("simpop_rx_empty", rx_valid, 0);

    // Ignored requests: zero length, start while busy, stray eng_done
    clear_model(); eng_mode = 0; eng_rand = 1'b0; eng_delay = 1;
    start_frame(0);
    check("len0_ss", ss, 1);
    repeat (5) @(negedge clk);
    check("len0_busy", frame_busy, 0);
    push_tx(8'h5A);
    push_tx(8'hC3);
    start_frame(2);
    frame_len = LW'(5); frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_idle(100);
    repeat (10) @(negedge clk);
    check("busy_start_ss", ss, 1);
    check("busy_start_sent_cnt", sent_q.size(), 2);
    drain(8'h5A);
    drain(8'hC3);
    eng_data_out = 8'h77; eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0; eng_data_out = 8'h00;
    @(negedge clk);
    check("stray_done_rx", rx_valid, 0);
    check("stray_done_ovf", ovf_cnt, 0);

    // Reset during the second WAIT of a 3-byte frame
    clear_model(); eng_mode = 0; eng_rand = 1'b0; eng_delay = 12;
    for (int i = 0; i < 3; i++) push_tx(8'($urandom));
    start_frame(3);
    for (int n = 0; n < 100 && sent_q.size() < 2; n++) @(negedge clk);
    check("midrst_reached_wait2", sent_q.size(), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ss", ss, 1);
    check("midrst_busy", frame_busy, 0);
    check("midrst_tx_ready", tx_ready, 1);
    check("midrst_rx_valid", rx_valid, 0);
    repeat (20) @(negedge clk);
    check("midrst_no_restart", sent_q.size(), 2);
    check("midrst_rx_still_empty", rx_valid, 0);

    check("ss_busy_consistency", ss_glitch, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
